decoder_stream_driver: RTL and testbench
========================================

Name: decoder_stream_driver

Overview:
Host-side sequencer that feeds the decoder block's x_t valid/ready stream and drains its y_t result stream. The host loads a token buffer, pulses start, and the driver issues cfg_start to the decoder. It then streams len words out while concurrently capturing len result words into a result buffer, and pulses done when finished. It sits between the host/register interface and decoder_block_top, as the initiator of the decoder's input stream and the consumer of its output stream.

Parameters:
DATA_WIDTH, 16, width of x/y stream words
DEPTH, 16, entries in each of the input and result buffers (power of 2, at least 2)
ADDR_W, $clog2(DEPTH), buffer index width (derived)
TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
host_wr_en  in  1  write input buffer entry
host_wr_addr  in  ADDR_W  input buffer write index
host_wr_data  in  DATA_WIDTH  input buffer write data
host_rd_addr  in  ADDR_W  result buffer read index
host_rd_data  out  DATA_WIDTH  result buffer read data, registered, 1-cycle latency
start  in  1  start pulse
len  in  ADDR_W+1  words to process, sampled on an accepted start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
timeout_err  out  1  sticky abort flag; tied 0 unless the optional feature is compiled in
dec_cfg_start  out  1  one-cycle config pulse to the decoder
dec_in_valid  out  1  x stream valid
dec_in_ready  in  1  x stream ready
dec_x_data  out  DATA_WIDTH  x stream data
dec_out_valid  in  1  y stream valid
dec_out_ready  out  1  y stream ready
dec_y_data  in  DATA_WIDTH  y stream data

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, FSM IDLE, counters 0, both buffers cleared to 0, timeout_err 0.
- FSM states: IDLE, CFG, RUN, DONE.
- IDLE:
  - start accepted only in IDLE; start in any other state is ignored.
  - On start: latch len_q = min(len, DEPTH), clear tx_cnt/rx_cnt and timeout_err.
  - len_q==0 goes to DONE; otherwise goes to CFG.
- CFG: dec_cfg_start=1 for exactly this one cycle, then RUN.
- RUN, transmit side:
  - dec_in_valid = (tx_cnt < len_q).
  - dec_x_data = in_buf[tx_cnt], driven combinationally from flops.
  - tx_cnt increments on dec_in_valid && dec_in_ready.
  - Valid and data stay stable while valid && !ready; valid never drops before a handshake.
- RUN, receive side:
  - dec_out_ready = (rx_cnt < len_q).
  - On dec_out_valid && dec_out_ready: res_buf[rx_cnt] <= dec_y_data, rx_cnt++.
  - Transmit and receive handshakes may occur in the same cycle and are independent.
  - Extra dec_out_valid after rx_cnt==len_q is not consumed.
- RUN exit: when rx_cnt reaches len_q (the cycle after the final rx handshake), go to DONE. tx completion alone does not exit.
- DONE: done=1 for one cycle, then IDLE. busy=1 in CFG, RUN and DONE; busy=0 in IDLE.
- Host writes: in_buf writes are performed only in IDLE; writes while busy are dropped.
- Host reads: host_rd_data <= res_buf[host_rd_addr] every cycle, in any state.
- Counter widths: tx_cnt and rx_cnt are ADDR_W+1 bits; indices use the low ADDR_W bits, and counters never exceed DEPTH.
- Latency: start at cycle N gives dec_cfg_start at N+1, with the first dec_in_valid possible at N+2.

Optional Feature:
Macro DECODER_DRIVER_TIMEOUT_EN.
- Defined:
  - In RUN, a watchdog counts cycles since the last rx handshake and resets on each one.
  - At TIMEOUT_CYCLES the driver aborts to DONE, sets timeout_err (held until the next accepted start), and deasserts both stream valid/ready.
- Undefined: no watchdog logic; timeout_err is constant 0; RUN waits indefinitely.

Decomposition:
- Package decoder_drv_pkg:
  - state enum typedef drv_state_e {IDLE, CFG, RUN, DONE}
  - function clamp_len
- One sub-module decoder_drv_buf:
  - DEPTH x DATA_WIDTH flop array with async clear, one write port and one combinational read port.
  - Instantiated twice: the input buffer (read by tx_cnt) and the result buffer (host read path registered in the parent).

Test Plan:
1. Load in_buf[0..3]=0x0001..0x0004, len=4, decoder model echoing +0x0100 with 2-cycle latency and always ready -> one dec_cfg_start at start+1; res_buf[0..3]=0x0101..0x0104; one done pulse; busy low after.
2. Same data, dec_in_ready toggling every cycle and dec_out_valid random -> dec_x_data stable while stalled; exactly 4 tx and 4 rx handshakes; results in order.
3. len=0 -> done pulse at start+1, no dec_cfg_start, no dec_in_valid, busy high for exactly one cycle.
4. DEPTH=16, len=20 -> exactly 16 tx and 16 rx handshakes; res_buf[15] written; done pulse.
5. During RUN, pulse start with len=2 and write in_buf[0]=0xFFFF -> both ignored; after done, in_buf[0] is unchanged. Then assert rst_n=0 mid-RUN after 2 tx handshakes -> outputs 0 immediately (asynchronous), buffers read 0; a subsequent len=1 run completes normally.
6. With DECODER_DRIVER_TIMEOUT_EN, TIMEOUT_CYCLES=8, decoder never asserts dec_out_valid -> abort 8 cycles into RUN, done pulse, timeout_err=1 until the next start. Without the macro, timeout_err stays 0 and busy stays high.

Source files
------------

// File: rtl/decoder_drv_pkg.sv
// Shared types and helpers for the decoder stream driver.
// The optional watchdog is enabled with DECODER_DRIVER_TIMEOUT_EN.
package decoder_drv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CFG,
        RUN,
        DONE
    } drv_state_e;

    function automatic int unsigned clamp_len(
        input int unsigned len,
        input int unsigned depth
    );
        return (len > depth) ? depth : len;
    endfunction

endpackage

// File: rtl/decoder_drv_buf.sv
// Flop-array buffer: async clear, one write port, one combinational read.
module decoder_drv_buf
    import decoder_drv_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/decoder_stream_driver.sv
// Host-side sequencer feeding the decoder x stream and draining y results.
// Define DECODER_DRIVER_TIMEOUT_EN to build the RUN-state watchdog.
module decoder_stream_driver
    import decoder_drv_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  host_wr_en,
    input  logic [ADDR_W-1:0]     host_wr_addr,
    input  logic [DATA_WIDTH-1:0] host_wr_data,
    input  logic [ADDR_W-1:0]     host_rd_addr,
    output logic [DATA_WIDTH-1:0] host_rd_data,
    input  logic                  start,
    input  logic [ADDR_W:0]       len,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic                  dec_cfg_start,
    output logic                  dec_in_valid,
    input  logic                  dec_in_ready,
    output logic [DATA_WIDTH-1:0] dec_x_data,
    input  logic                  dec_out_valid,
    output logic                  dec_out_ready,
    input  logic [DATA_WIDTH-1:0] dec_y_data
);

    localparam int CNT_W = ADDR_W + 1;

    drv_state_e            state_q, state_d;
    logic [CNT_W-1:0]      len_q, len_d;
    logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
    logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
    logic [DATA_WIDTH-1:0] host_rd_data_q, host_rd_data_d;
    logic [DATA_WIDTH-1:0] res_rd_data;
    logic                  tx_hs, rx_hs, in_wr_en, wd_hit, start_acc;

    assign start_acc     = (state_q == IDLE) && start;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign dec_cfg_start = (state_q == CFG);
    assign dec_in_valid  = (state_q == RUN) && (tx_cnt_q < len_q);
    assign dec_out_ready = (state_q == RUN) && (rx_cnt_q < len_q);
    assign tx_hs         = dec_in_valid && dec_in_ready;
    assign rx_hs         = dec_out_valid && dec_out_ready;
    assign in_wr_en      = host_wr_en && (state_q == IDLE);
    assign host_rd_data  = host_rd_data_q;

    decoder_drv_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_in_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (in_wr_en),
        .wr_addr(host_wr_addr),
        .wr_data(host_wr_data),
        .rd_addr(tx_cnt_q[ADDR_W-1:0]),
        .rd_data(dec_x_data)
    );

    decoder_drv_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_res_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (rx_hs),
        .wr_addr(rx_cnt_q[ADDR_W-1:0]),
        .wr_data(dec_y_data),
        .rd_addr(host_rd_addr),
        .rd_data(res_rd_data)
    );

`ifdef DECODER_DRIVER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_err_q, timeout_err_d;

    // Counts RUN cycles since the last result; a normal finish wins a tie.
    assign wd_hit = (state_q == RUN) && !rx_hs
                 && (rx_cnt_q != len_q)
                 && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeout_err_q;

    always_comb begin
        wd_cnt_d      = '0;
        timeout_err_d = timeout_err_q;
        if ((state_q == RUN) && !rx_hs) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
        if (start_acc) begin
            timeout_err_d = 1'b0;
        end else if (wd_hit) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
`else
    assign wd_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        tx_cnt_d       = tx_cnt_q;
        rx_cnt_d       = rx_cnt_q;
        host_rd_data_d = res_rd_data;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d    = CNT_W'(clamp_len(32'(len), DEPTH));
                    tx_cnt_d = '0;
                    rx_cnt_d = '0;
                    state_d  = (len_d == '0) ? DONE : CFG;
                end
            end
            CFG: state_d = RUN;
            RUN: begin
                if (tx_hs) tx_cnt_d = tx_cnt_q + 1'b1;
                if (rx_hs) rx_cnt_d = rx_cnt_q + 1'b1;
                if ((rx_cnt_q == len_q) || wd_hit) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            len_q          <= '0;
            tx_cnt_q       <= '0;
            rx_cnt_q       <= '0;
            host_rd_data_q <= '0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            tx_cnt_q       <= tx_cnt_d;
            rx_cnt_q       <= rx_cnt_d;
            host_rd_data_q <= host_rd_data_d;
        end
    end

endmodule

// File: tb/tb_decoder_stream_driver.sv
// Directed bench for decoder_stream_driver with an echo decoder model.
// Honours DECODER_DRIVER_TIMEOUT_EN for the watchdog sequence.
module tb_decoder_stream_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_wr_en = 1'b0;
    logic [3:0]  host_wr_addr = '0;
    logic [15:0] host_wr_data = '0;
    logic [3:0]  host_rd_addr = '0;
    logic [15:0] host_rd_data;
    logic        start = 1'b0;
    logic [4:0]  len = '0;
    logic        busy, done, timeout_err, dec_cfg_start;
    logic        dec_in_valid;
    logic        dec_in_ready = 1'b0;
    logic [15:0] dec_x_data;
    logic        dec_out_valid = 1'b0;
    logic        dec_out_ready;
    logic [15:0] dec_y_data = '0;

    decoder_stream_driver #(
        .DATA_WIDTH    (16),
        .DEPTH         (16),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host_wr_en   (host_wr_en),
        .host_wr_addr (host_wr_addr),
        .host_wr_data (host_wr_data),
        .host_rd_addr (host_rd_addr),
        .host_rd_data (host_rd_data),
        .start        (start),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .timeout_err  (timeout_err),
        .dec_cfg_start(dec_cfg_start),
        .dec_in_valid (dec_in_valid),
        .dec_in_ready (dec_in_ready),
        .dec_x_data   (dec_x_data),
        .dec_out_valid(dec_out_valid),
        .dec_out_ready(dec_out_ready),
        .dec_y_data   (dec_y_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  len;
        bit          stall;
        bit          rnd;
        logic [15:0] base;
        int          exp_n;
    } vec_t;

    vec_t        vecs[5];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          s_cyc, cfg_cyc, done_cyc;
    int          tx_n, rx_n, cfg_n, done_n, busy_n, stab_err;
    bit          stall_m = 0, rnd_m = 0, never_v = 0, rdy_tog = 0;
    bit          prev_v = 0, prev_r = 0;
    logic [15:0] prev_x = '0;
    logic [15:0] pend_d[$];
    int          pend_t[$];
    logic [15:0] rdv;
    int          dmy;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // One cycle: drive decoder-side inputs, observe, advance.
    task automatic tick();
        dec_in_ready = stall_m ? rdy_tog : 1'b1;
        rdy_tog = ~rdy_tog;
        if (pend_d.size() > 0 && pend_t[0] <= cyc && !never_v
            && (!rnd_m || $urandom_range(0, 1) == 1)) begin
            dec_out_valid = 1'b1;
            dec_y_data = pend_d[0];
        end else begin
            dec_out_valid = 1'b0;
            dec_y_data = '0;
        end
        #1;
        if (dec_cfg_start) begin cfg_n++; cfg_cyc = cyc; end
        if (done) begin done_n++; done_cyc = cyc; end
        if (busy) busy_n++;
        if (prev_v && !prev_r) begin
            if (!dec_in_valid || dec_x_data != prev_x) stab_err++;
        end
        prev_v = dec_in_valid;
        prev_r = dec_in_ready;
        prev_x = dec_x_data;
        if (dec_in_valid && dec_in_ready) begin
            tx_n++;
            pend_d.push_back(dec_x_data + 16'h0100);
            pend_t.push_back(cyc + 2);
        end
        if (dec_out_valid && dec_out_ready) begin
            rx_n++;
            rdv = pend_d.pop_front();
            dmy = pend_t.pop_front();
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clr();
        tx_n = 0; rx_n = 0; cfg_n = 0; done_n = 0;
        busy_n = 0; stab_err = 0; prev_v = 0;
        pend_d.delete();
        pend_t.delete();
    endtask

    task automatic do_start(input logic [4:0] l);
        start = 1'b1;
        len = l;
        s_cyc = cyc;
        tick();
        start = 1'b0;
        len = '0;
    endtask

    task automatic load(input logic [15:0] base);
        for (int i = 0; i < 16; i++) begin
            host_wr_en = 1'b1;
            host_wr_addr = 4'(i);
            host_wr_data = base + 16'(i);
            tick();
        end
        host_wr_en = 1'b0;
    endtask

    task automatic rd(input int a, output logic [15:0] d);
        host_rd_addr = 4'(a);
        tick();
        d = host_rd_data;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_n == 0; i++) tick();
        if (done_n == 0) chk("done_wait_expired", 0, 1);
    endtask

    task automatic run_job(input logic [4:0] l);
        clr();
        do_start(l);
        wait_done(300);
        tick();
    endtask

    initial begin
        vecs[0] = '{5'd4,  1'b0, 1'b0, 16'h0001, 4};
        vecs[1] = '{5'd4,  1'b1, 1'b1, 16'h0011, 4};
        vecs[2] = '{5'd20, 1'b0, 1'b0, 16'h0200, 16};
        vecs[3] = '{5'd16, 1'b1, 1'b0, 16'h3000, 16};
        vecs[4] = '{5'd0,  1'b0, 1'b0, 16'h0050, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg", dec_cfg_start, 0);
        chk("rst_in_valid", dec_in_valid, 0);
        chk("rst_out_ready", dec_out_ready, 0);
        chk("rst_x_data", dec_x_data, 0);
        chk("rst_rd_data", host_rd_data, 0);
        chk("rst_timeout", timeout_err, 0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            load(vecs[v].base);
            stall_m = vecs[v].stall;
            rnd_m = vecs[v].rnd;
            run_job(vecs[v].len);
            chk($sformatf("v%0d_cfg_cnt", v), cfg_n,
                (vecs[v].exp_n > 0) ? 1 : 0);
            chk($sformatf("v%0d_done_cnt", v), done_n, 1);
            chk($sformatf("v%0d_tx", v), tx_n, vecs[v].exp_n);
            chk($sformatf("v%0d_rx", v), rx_n, vecs[v].exp_n);
            chk($sformatf("v%0d_stable", v), stab_err, 0);
            chk($sformatf("v%0d_busy_after", v), busy, 0);
            if (vecs[v].exp_n > 0) begin
                chk($sformatf("v%0d_cfg_lat", v), cfg_cyc - s_cyc, 1);
            end else begin
                chk($sformatf("v%0d_done_lat", v), done_cyc - s_cyc, 1);
                chk($sformatf("v%0d_busy_len", v), busy_n, 1);
            end
            stall_m = 0;
            rnd_m = 0;
            for (int i = 0; i < vecs[v].exp_n; i++) begin
                rd(i, rdv);
                chk($sformatf("v%0d_res%0d", v, i), rdv,
                    vecs[v].base + 16'(i) + 16'h0100);
            end
        end

        // Start and host write during RUN are both dropped.
        load(16'h0100);
        clr();
        stall_m = 1;
        do_start(5'd4);
        repeat (3) tick();
        start = 1'b1;
        len = 5'd2;
        host_wr_en = 1'b1;
        host_wr_addr = 4'd0;
        host_wr_data = 16'hFFFF;
        tick();
        start = 1'b0;
        len = '0;
        host_wr_en = 1'b0;
        wait_done(100);
        tick();
        stall_m = 0;
        chk("ign_done_cnt", done_n, 1);
        chk("ign_cfg_cnt", cfg_n, 1);
        chk("ign_tx", tx_n, 4);
        run_job(5'd1);
        rd(0, rdv);
        chk("ign_inbuf0", rdv, 16'h0200);

        // Asynchronous reset in the middle of RUN.
        clr();
        do_start(5'd4);
        for (int i = 0; i < 20 && tx_n < 2; i++) tick();
        chk("mid_tx2", tx_n, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_in_valid", dec_in_valid, 0);
        chk("mid_out_ready", dec_out_ready, 0);
        chk("mid_x_data", dec_x_data, 0);
        chk("mid_rd_data", host_rd_data, 0);
        clr();
        tick();
        tick();
        rst_n = 1'b1;
        rd(0, rdv);
        chk("mid_res_clr", rdv, 0);
        host_wr_en = 1'b1;
        host_wr_addr = 4'd0;
        host_wr_data = 16'h0ABC;
        tick();
        host_wr_en = 1'b0;
        run_job(5'd1);
        chk("post_rst_rx", rx_n, 1);
        rd(0, rdv);
        chk("post_rst_res", rdv, 16'h0BBC);

        // Decoder never produces results.
        clr();
        never_v = 1;
        do_start(5'd2);
`ifdef DECODER_DRIVER_TIMEOUT_EN
        wait_done(40);
        chk("to_done_lat", done_cyc - s_cyc, 10);
        chk("to_err_set", timeout_err, 1);
        chk("to_busy", busy, 0);
        repeat (3) tick();
        chk("to_err_hold", timeout_err, 1);
        never_v = 0;
        clr();
        do_start(5'd0);
        chk("to_err_clr", timeout_err, 0);
        tick();
`else
        repeat (40) tick();
        chk("nto_busy", busy, 1);
        chk("nto_done", done_n, 0);
        chk("nto_err", timeout_err, 0);
        never_v = 0;
        rst_n = 1'b0;
        clr();
        tick();
        rst_n = 1'b1;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
